// File: rtl/ls_counter_pkg.sv
// Shared helpers for the counter bank: parameter legality and counter width.
package ls_counter_pkg;

  // Smallest register width able to hold every count of a given modulus.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (width >= 1) && (width <= 16) &&
           (cnt_width(modulus) <= width);
  endfunction

endpackage

// File: rtl/ls_counter_chan.sv
// One counter channel: falling-edge detector on a, CLR > LOAD > increment
// priority, registered terminal-count pulse.
module ls_counter_chan
  import ls_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             inc_in,
  output logic             fall_out,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic a_prev;
  logic at_top;

  // >= rather than == so a loaded value beyond the modulus still wraps to 0.
  assign at_top   = (q >= TOP);
  assign fall_out = a_prev & ~a;
  assign wrap_out = inc_in & at_top & ~clr & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prev <= 1'b0;
      q      <= '0;
      tc     <= 1'b0;
    end else begin
      a_prev <= a;
      tc     <= wrap_out;
      if (clr) begin
        q <= '0;
      end else if (load) begin
        q <= d;
      end else if (inc_in) begin
        q <= at_top ? '0 : q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ls393_counter_bank.sv
// Bank of CH modulo-MODULUS counters; with CASCADE set, each channel above 0
// counts on the same-cycle wrap of the channel below it.
module ls393_counter_bank
  import ls_counter_pkg::*;
#(
  parameter int CH      = 2,
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int CASCADE = 0
) (
  input  logic                CLK,
  input  logic                _RST,
  input  logic [CH-1:0]       A,
  input  logic [CH-1:0]       CLR,
  input  logic [CH-1:0]       LOAD,
  input  logic [CH*WIDTH-1:0] D,
  output logic [CH*WIDTH-1:0] Q,
  output logic [CH-1:0]       TC
);

  if (!modulus_ok(WIDTH, MODULUS) || CH < 1) begin : g_bad_params
    $error("ls393_counter_bank: illegal CH/WIDTH/MODULUS combination");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic fall;
    logic inc;
    logic wrap;

    if (i == 0) begin : g_first
      assign inc = fall;
    end else begin : g_rest
      // Carry is combinational: a full chain wrap lands on a single edge.
      assign inc = (CASCADE != 0) ? g_ch[i-1].wrap : fall;
    end

    ls_counter_chan #(
      .WIDTH  (WIDTH),
      .MODULUS(MODULUS)
    ) u_chan (
      .clk     (CLK),
      .rst_n   (_RST),
      .a       (A[i]),
      .clr     (CLR[i]),
      .load    (LOAD[i]),
      .d       (D[i*WIDTH +: WIDTH]),
      .inc_in  (inc),
      .fall_out(fall),
      .q       (Q[i*WIDTH +: WIDTH]),
      .tc      (TC[i]),
      .wrap_out(wrap)
    );
  end

endmodule

// File: tb/tb_ls393_counter_bank.sv
// Bench for ls393_counter_bank: three configurations (binary, decade,
// cascaded) checked every cycle against an arithmetic model plus literal checks.
module tb_ls393_counter_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0][1:0] a, clr, load, tc;
  logic [2:0][7:0] d, q;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // k=0: binary mod 16, k=1: decade, k=2: cascaded mod 16
  ls393_counter_bank #(.CH(2), .WIDTH(4), .MODULUS(16), .CASCADE(0)) dut_bin (
    .CLK(clk), ._RST(rst_n), .A(a[0]), .CLR(clr[0]), .LOAD(load[0]),
    .D(d[0]), .Q(q[0]), .TC(tc[0]));
  ls393_counter_bank #(.CH(2), .WIDTH(4), .MODULUS(10), .CASCADE(0)) dut_dec (
    .CLK(clk), ._RST(rst_n), .A(a[1]), .CLR(clr[1]), .LOAD(load[1]),
    .D(d[1]), .Q(q[1]), .TC(tc[1]));
  ls393_counter_bank #(.CH(2), .WIDTH(4), .MODULUS(16), .CASCADE(1)) dut_cas (
    .CLK(clk), ._RST(rst_n), .A(a[2]), .CLR(clr[2]), .LOAD(load[2]),
    .D(d[2]), .Q(q[2]), .TC(tc[2]));

  // ---------------- reference model ----------------
  int mq[3][2];
  bit mtc[3][2];
  bit mprev[3][2];

  function automatic int mod_of(input int k);
    return (k == 1) ? 10 : 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 2; i++) begin
          mq[k][i]    <= 0;
          mtc[k][i]   <= 1'b0;
          mprev[k][i] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit carry;
        carry = 1'b0;
        for (int i = 0; i < 2; i++) begin
          bit step, top, wrap;
          top  = (mq[k][i] >= mod_of(k) - 1);
          step = (k == 2 && i > 0) ? carry : (mprev[k][i] && !a[k][i]);
          wrap = step && top && !clr[k][i] && !load[k][i];
          if (clr[k][i])       mq[k][i] <= 0;
          else if (load[k][i]) mq[k][i] <= int'(d[k][i*4 +: 4]);
          else if (step)       mq[k][i] <= top ? 0 : mq[k][i] + 1;
          mtc[k][i]   <= wrap;
          mprev[k][i] <= a[k][i];
          carry = wrap;
        end
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (int'(q[k][i*4 +: 4]) != mq[k][i] || tc[k][i] != mtc[k][i]) begin
          n_bad++;
          $display("FAIL model_cmp dut%0d ch%0d t=%0t: got q=%0d tc=%0b, required q=%0d tc=%0b",
                   k, i, $time, q[k][i*4 +: 4], tc[k][i], mq[k][i], mtc[k][i]);
        end
      end
  end

  // ---------------- driver / literal checks ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, got, exp);
    end
  endtask

  // High sample then low sample; returns at the negedge after the counting edge.
  task automatic fall_pulse(input int k, input int i);
    @(negedge clk); #1 a[k][i] = 1'b1;
    @(negedge clk); #1 a[k][i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    a = '0; clr = '0; load = '0; d = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_q", int'(q[k]), 0);
      chk("reset_tc", int'(tc[k]), 0);
    end
    #1 rst_n = 1'b1;

    // binary: 16 falls walk Q0 1..15 then 0 with a TC pulse; ch1 untouched
    for (int n = 1; n <= 16; n++) begin
      fall_pulse(0, 0);
      chk("bin_q0", int'(q[0][3:0]), n % 16);
      chk("bin_tc0", int'(tc[0][0]), (n == 16) ? 1 : 0);
      chk("bin_q1", int'(q[0][7:4]), 0);
    end
    @(negedge clk);
    chk("bin_tc_one_cycle", int'(tc[0][0]), 0);

    // decade
    for (int n = 1; n <= 10; n++) begin
      fall_pulse(1, 0);
      chk("dec_q0", int'(q[1][3:0]), n % 10);
      chk("dec_tc0", int'(tc[1][0]), (n == 10) ? 1 : 0);
    end
    #1 load[1][0] = 1'b1; d[1][3:0] = 4'd12;
    @(negedge clk);
    chk("dec_load12", int'(q[1][3:0]), 12);
    #1 load[1][0] = 1'b0;
    fall_pulse(1, 0);
    chk("dec_over_q", int'(q[1][3:0]), 0);
    chk("dec_over_tc", int'(tc[1][0]), 1);

    // A held low after one fall counts once
    fall_pulse(0, 0);
    repeat (20) @(negedge clk);
    chk("held_low_q", int'(q[0][3:0]), 1);

    // fall + CLR with Q at the top: no wrap, no TC
    #1 load[0][0] = 1'b1; d[0][3:0] = 4'd15;
    @(negedge clk); #1 load[0][0] = 1'b0;
    @(negedge clk); #1 a[0][0] = 1'b1;
    @(negedge clk); #1 a[0][0] = 1'b0; clr[0][0] = 1'b1;
    @(negedge clk);
    chk("fall_clr_q", int'(q[0][3:0]), 0);
    chk("fall_clr_tc", int'(tc[0][0]), 0);
    #1 clr[0][0] = 1'b0;

    // fall + LOAD 5
    @(negedge clk); #1 a[0][0] = 1'b1;
    @(negedge clk); #1 a[0][0] = 1'b0; load[0][0] = 1'b1; d[0][3:0] = 4'd5;
    @(negedge clk);
    chk("fall_load_q", int'(q[0][3:0]), 5);
    chk("fall_load_tc", int'(tc[0][0]), 0);
    #1 load[0][0] = 1'b0;

    // reset released with A low: no count until high then low
    @(negedge clk); #1 a[0][0] = 1'b1;
    @(negedge clk); #1 rst_n = 1'b0; a[0][0] = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_low_a_q", int'(q[0][3:0]), 0);
    fall_pulse(0, 0);
    chk("rst_first_fall_q", int'(q[0][3:0]), 1);

    // cascade: 256 falls walk {Q1,Q0} 0x01..0xFF then 0x00; A[1] ignored
    for (int n = 1; n <= 256; n++) begin
      a[2][1] = 1'($urandom);
      fall_pulse(2, 0);
      chk("cas_q", int'(q[2]), n % 256);
      chk("cas_tc", int'(tc[2]), (n == 256) ? 3 : ((n % 16 == 0) ? 1 : 0));
    end
    a[2][1] = 1'b0;

    // asynchronous reset with Q=7
    #1 load[0][0] = 1'b1; d[0][3:0] = 4'd7;
    @(negedge clk);
    chk("pre_async_q", int'(q[0][3:0]), 7);
    #1 load[0][0] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", int'(q[0]), 0);
    chk("async_rst_tc", int'(tc[0]), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // randomized traffic on all three banks
    repeat (3000) begin
      @(negedge clk); #1;
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 2; i++) begin
          a[k][i]    = 1'($urandom);
          clr[k][i]  = ($urandom_range(19) == 0);
          load[k][i] = ($urandom_range(15) == 0);
        end
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom);
    end
    #1 a = '0; clr = '0; load = '0;
    repeat (4) @(negedge clk);

    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
